// File: rtl/decrypt_core.sv
// rtl/decrypt_core.sv - iterative AES-128 inverse cipher, one round per clock
// Round keys are unwound backwards from the stored round-10 key, so no key table is kept.
module decrypt_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  input  logic         key_keep,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         key_loaded
);

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t       stateReg, nextState;
  logic [127:0] st, rk, k10Reg, ctReg;
  logic [7:0]   rcon;
  logic [3:0]   cnt;
  logic         accept, useKept;
  logic [127:0] nextRk, prevRk, roundOut;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return INV_SBOX[{a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bytes are little-endian within a word, so RotWord is a rotate toward bit 0.
  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    logic [31:0] r;
    r = {w[7:0], w[31:8]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] fwdExpand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[31:0] ^ subRotWord(k[127:96]) ^ {24'h0, rc};
    n1 = k[63:32] ^ n0;
    n2 = k[95:64] ^ n1;
    n3 = k[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  function automatic logic [127:0] invExpand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[127:96] ^ k[95:64];
    p2 = k[95:64] ^ k[63:32];
    p1 = k[63:32] ^ k[31:0];
    p0 = k[31:0] ^ subRotWord(p3) ^ {24'h0, rc};
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [7:0] rconOf(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[8*i +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  function automatic logic [127:0] invRound(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [127:0] t, m;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[8*(4*c+r) +: 8] = invSbox(s[8*(4*((c - r + 4) % 4) + r) +: 8]);
      end
    end
    t = t ^ k;
    for (int c = 0; c < 4; c++) begin
      m[32*c +: 32] = invMixCol(t[32*c +: 32]);
    end
    return last ? t : m;
  endfunction

  assign in_ready = (stateReg == IDLE);
  assign accept   = in_valid & in_ready;
  assign useKept  = key_keep & key_loaded;
  assign nextRk   = fwdExpand(rk, rcon);
  assign prevRk   = invExpand(rk, rconOf(cnt + 4'd1));
  assign roundOut = invRound(st, prevRk, cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= nextState;
  end

  always_comb begin
    nextState = stateReg;
    case (stateReg)
      IDLE:    if (accept) nextState = useKept ? ROUND : KEYEXP;
      KEYEXP:  if (cnt == LAST_CNT) nextState = ROUND;
      ROUND:   if (cnt == 4'd0) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= '0;
      rk         <= '0;
      k10Reg     <= '0;
      ctReg      <= '0;
      rcon       <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      plaintext  <= '0;
      key_loaded <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (accept) begin
            if (useKept) begin
              st  <= ciphertext ^ k10Reg;
              rk  <= k10Reg;
              cnt <= LAST_CNT;
            end else begin
              ctReg <= ciphertext;
              rk    <= key;
              rcon  <= 8'h01;
              cnt   <= 4'd0;
            end
          end
        end
        KEYEXP: begin
          rk   <= nextRk;
          rcon <= xtime(rcon);
          if (cnt == LAST_CNT) begin
            st         <= ctReg ^ nextRk;
            k10Reg     <= nextRk;
            key_loaded <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          st <= roundOut;
          rk <= prevRk;
          if (cnt == 4'd0) begin
            plaintext <= roundOut;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_core.sv
// tb/tb_decrypt_core.sv - directed and randomised checks of decrypt_core against a byte-level AES model
module tb_decrypt_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         key_keep = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, key_loaded;
  logic [127:0] plaintext;

  int total = 0;
  int bad = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  decrypt_core #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .key_keep(key_keep),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext),
    .key_loaded(key_loaded)
  );

  always #5 clk = ~clk;

  // FIPS-197 byte lists are written first-byte-leftmost; the core wants byte 0 in [7:0].
  function automatic logic [127:0] rev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[(15-n) -: 8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[a] = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] refDecrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  coef [4];
    logic [7:0]  rc;
    logic [31:0] tmp;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = {k[8*(4*i) +: 8], k[8*(4*i+1) +: 8], k[8*(4*i+2) +: 8], k[8*(4*i+3) +: 8]};
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = ct[8*n +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[40+c][31-8*r -: 8];
    for (int round = 9; round >= 0; round--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = isb[s[r+4*((c-r+4)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*c] ^ w[4*round+c][31-8*r -: 8];
      if (round > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            t[r+4*c] = 8'h00;
            for (int j = 0; j < 4; j++)
              t[r+4*c] = t[r+4*c] ^ gmul(coef[(j-r+4)%4], s[j+4*c]);
          end
        end
        for (int n = 0; n < 16; n++) s[n] = t[n];
      end
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic runBlock(input string tag, input logic [127:0] ct, input logic [127:0] k,
                          input logic keep, input int expLat, input logic [127:0] expPt,
                          input int hold);
    int n;
    logic seen;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, 128'(in_ready), 128'(1));
    ciphertext = ct;
    key = k;
    key_keep = keep;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key = '1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      n++;
      @(posedge clk); #1;
      seen = out_valid;
    end
    check({tag, "_latency"}, 128'(n), 128'(expLat));
    check({tag, "_pt"}, plaintext, expPt);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      check({tag, "_hold_pt"}, plaintext, expPt);
      check({tag, "_hold_ready"}, 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 128'(out_valid), 128'(0));
    check({tag, "_idle"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] c1Key, c1Ct, c1Pt, bCt, rk, rct, effKey;
    logic         loaded, keep;
    int           lat;

    buildSbox();
    c1Key = rev(128'h000102030405060708090a0b0c0d0e0f);
    c1Ct  = rev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    c1Pt  = rev(128'h00112233445566778899aabbccddeeff);
    bCt   = rev(128'h3925841d02dc09fbdc118597196a0b32);

    #12;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_plaintext", plaintext, 128'(0));
    check("rst_key_loaded", 128'(key_loaded), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    runBlock("c1", c1Ct, c1Key, 1'b0, 20, c1Pt, 7);
    check("c1_key_loaded", 128'(key_loaded), 128'(1));
    check("c1_k10", dut.k10Reg, rev(128'h13111d7fe3944a17f307a78b4d2b30c5));

    runBlock("keep_b", bCt, '1, 1'b1, 10, refDecrypt(bCt, c1Key), 0);

    ciphertext = c1Ct;
    key = c1Key;
    key_keep = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_plaintext", plaintext, 128'(0));
    check("midrst_key_loaded", 128'(key_loaded), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    runBlock("postrst_keep", c1Ct, c1Key, 1'b1, 20, c1Pt, 0);

    loaded = 1'b1;
    effKey = c1Key;
    for (int i = 0; i < 200; i++) begin
      keep = 1'($urandom_range(0, 1));
      rk   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rct  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!(keep && loaded)) begin
        effKey = rk;
        lat = 20;
      end else begin
        lat = 10;
      end
      runBlock($sformatf("rand%0d", i), rct, rk, keep, lat, refDecrypt(rct, effKey),
               $urandom_range(0, 2));
      loaded = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
